lc_bridge_req_arbiter: RTL and testbench

//  Shares one LC-side TX port of the LC/bus bridge (ADDR/DATA/REQ/ACK, 4-phase) among
//  NUM_REQ layer-controller requesters. Round-robin grant; winner's ADDR/DATA latched at

---
 rtl/lc_bridge_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_lc_bridge_req_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc_bridge_req_arbiter.sv
// lc_bridge_req_arbiter
// Round-robin arbiter that shares one LC-side TX port of the LC/bus bridge among
// NUM_REQ layer-controller requesters. Both sides use a 4-phase REQ/ACK handshake.
// The winner's ADDR/DATA are latched at grant and held until the next grant.
module lc_bridge_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic [NUM_REQ-1:0]                         REQ_IN,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]              ADDR_IN,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              DATA_IN,
    output logic [NUM_REQ-1:0]                         ACK_OUT,
    output logic [ADDR_WIDTH-1:0]                      ADDR_TO_BRIDGE,
    output logic [DATA_WIDTH-1:0]                      DATA_TO_BRIDGE,
    output logic                                       REQ_TO_BRIDGE,
    input  logic                                       ACK_FROM_BRIDGE,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] GRANT_ID,
    output logic                                       BUSY
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r;
    logic [IDW-1:0]          ptr_r;
    logic [IDW-1:0]          grant_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    req_r;
    logic [NUM_REQ-1:0]      ack_r;
    logic                    busy_r;

    logic [IDW-1:0]          win_s;
    logic                    win_valid_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    grant_req_s;
    logic [NUM_REQ-1:0]      ack_onehot_s;
    logic [IDW-1:0]          ptr_next_s;

    // Round-robin scan: first requester found starting at ptr_r, wrapping modulo NUM_REQ.
    always_comb begin : scan_blk
        logic [IDW:0] sum_v;
        logic         bit_v;
        logic         hit_v;
        win_s       = '0;
        win_valid_s = 1'b0;
        sum_v       = '0;
        bit_v       = 1'b0;
        hit_v       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v = {1'b0, ptr_r} + (IDW+1)'(k);
            sum_v = (sum_v >= (IDW+1)'(NUM_REQ)) ? (sum_v - (IDW+1)'(NUM_REQ)) : sum_v;
            bit_v = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                bit_v = bit_v | ((sum_v == (IDW+1)'(j)) & REQ_IN[j]);
            end
            hit_v       = bit_v & ~win_valid_s;
            win_s       = hit_v ? sum_v[IDW-1:0] : win_s;
            win_valid_s = win_valid_s | hit_v;
        end
    end

    // AND-OR muxes: winner's payload, granted requester's REQ and its one-hot ACK.
    always_comb begin
        sel_addr_s   = '0;
        sel_data_s   = '0;
        grant_req_s  = 1'b0;
        ack_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s      = sel_addr_s | ({ADDR_WIDTH{win_s == IDW'(i)}}
                                            & ADDR_IN[i*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_data_s      = sel_data_s | ({DATA_WIDTH{win_s == IDW'(i)}}
                                            & DATA_IN[i*DATA_WIDTH +: DATA_WIDTH]);
            grant_req_s     = grant_req_s | ((grant_r == IDW'(i)) & REQ_IN[i]);
            ack_onehot_s[i] = (grant_r == IDW'(i));
        end
    end

    // Priority pointer moves to the requester just after the last winner.
    always_comb begin
        ptr_next_s = (grant_r == IDW'(NUM_REQ - 1)) ? '0 : (grant_r + IDW'(1));
    end

    // Handshake FSM with all outputs registered; RESET clears everything at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            req_r   <= 1'b0;
            ack_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A bridge ACK seen here belongs to nobody and is ignored.
                    if (win_valid_s) begin
                        addr_r  <= sel_addr_s;
                        data_r  <= sel_data_s;
                        grant_r <= win_s;
                        req_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // No timeout: the bridge is trusted to answer eventually.
                    if (ACK_FROM_BRIDGE) begin
                        req_r   <= 1'b0;
                        ack_r   <= ack_onehot_s;
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Both handshakes must be back to zero before the port is released.
                    if (!ACK_FROM_BRIDGE && !grant_req_s) begin
                        ack_r   <= '0;
                        ptr_r   <= ptr_next_s;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    ack_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ACK_OUT        = ack_r;
    assign ADDR_TO_BRIDGE = addr_r;
    assign DATA_TO_BRIDGE = data_r;
    assign REQ_TO_BRIDGE  = req_r;
    assign GRANT_ID       = grant_r;
    assign BUSY           = busy_r;

endmodule

// File: tb/tb_lc_bridge_req_arbiter.sv
// Testbench for lc_bridge_req_arbiter: directed vectors, expected grants queued by the
// stimulus and checked by an independent monitor on every rising REQ_TO_BRIDGE.
module tb_lc_bridge_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NR-1:0]     REQ_IN;
    logic [NR*AW-1:0]  ADDR_IN;
    logic [NR*DW-1:0]  DATA_IN;
    logic [NR-1:0]     ACK_OUT;
    logic [AW-1:0]     ADDR_TO_BRIDGE;
    logic [DW-1:0]     DATA_TO_BRIDGE;
    logic              REQ_TO_BRIDGE;
    logic              ACK_FROM_BRIDGE;
    logic [1:0]        GRANT_ID;
    logic              BUSY;

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lc_bridge_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ_IN          (REQ_IN),
        .ADDR_IN         (ADDR_IN),
        .DATA_IN         (DATA_IN),
        .ACK_OUT         (ACK_OUT),
        .ADDR_TO_BRIDGE  (ADDR_TO_BRIDGE),
        .DATA_TO_BRIDGE  (DATA_TO_BRIDGE),
        .REQ_TO_BRIDGE   (REQ_TO_BRIDGE),
        .ACK_FROM_BRIDGE (ACK_FROM_BRIDGE),
        .GRANT_ID        (GRANT_ID),
        .BUSY            (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ADDR_IN[i*AW +: AW] = a;
        DATA_IN[i*DW +: DW] = d;
    endtask

    task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.id   = 2'(i);
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_req();
        for (int c = 0; c < 20 && !REQ_TO_BRIDGE; c++) @(negedge CLK);
        check("req_seen", {63'd0, REQ_TO_BRIDGE}, 64'd1);
    endtask

    // Plays the bridge and requester g through one complete 4-phase exchange.
    task automatic run_bridge(input int g, input bit rearm);
        wait_req();
        ACK_FROM_BRIDGE = 1'b1;
        @(negedge CLK);
        check("ack_out_rise", {60'd0, ACK_OUT}, 64'd1 << g);
        check("req_drop", {63'd0, REQ_TO_BRIDGE}, 64'd0);
        ACK_FROM_BRIDGE = 1'b0;
        REQ_IN[g]       = 1'b0;
        @(negedge CLK);
        check("ack_out_fall", {60'd0, ACK_OUT}, 64'd0);
        check("busy_idle", {63'd0, BUSY}, 64'd0);
        if (rearm) REQ_IN[g] = 1'b1;
    endtask

    // Monitor: every new grant must match the head of the expected queue.
    initial begin : monitor
        logic prev;
        txn_t t;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (REQ_TO_BRIDGE && !prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got id %0d expected no grant", GRANT_ID);
                end else begin
                    t = exp_q.pop_front();
                    check("grant_id", {62'd0, GRANT_ID}, {62'd0, t.id});
                    check("grant_addr", {56'd0, ADDR_TO_BRIDGE}, {56'd0, t.addr});
                    check("grant_data", {32'd0, DATA_TO_BRIDGE}, {32'd0, t.data});
                    check("grant_busy", {63'd0, BUSY}, 64'd1);
                end
            end
            prev = REQ_TO_BRIDGE;
        end
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET           = 1'b1;
        REQ_IN          = '0;
        ADDR_IN         = '0;
        DATA_IN         = '0;
        ACK_FROM_BRIDGE = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_state", {16'd0, ACK_OUT, ADDR_TO_BRIDGE, DATA_TO_BRIDGE,
                              REQ_TO_BRIDGE, GRANT_ID, BUSY}, 64'd0);
        RESET = 1'b0;

        // Spurious bridge ACK while idle with nobody requesting.
        ACK_FROM_BRIDGE = 1'b1;
        repeat (3) @(negedge CLK);
        check("spurious_ack_out", {60'd0, ACK_OUT}, 64'd0);
        check("spurious_busy", {63'd0, BUSY}, 64'd0);
        check("spurious_req", {63'd0, REQ_TO_BRIDGE}, 64'd0);
        ACK_FROM_BRIDGE = 1'b0;
        @(negedge CLK);

        // Round robin with all four requesting: 0,1,2,3,0.
        for (int i = 0; i < NR; i++) set_src(i, 8'hA0 + 8'(i), 32'hC0DE0000 + 32'(i));
        push(0, 8'hA0, 32'hC0DE0000);
        push(1, 8'hA1, 32'hC0DE0001);
        push(2, 8'hA2, 32'hC0DE0002);
        push(3, 8'hA3, 32'hC0DE0003);
        push(0, 8'hA0, 32'hC0DE0000);
        REQ_IN = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_bridge(k % 4, k < 3);
            if (k == 3) REQ_IN = 4'b0001;
        end
        REQ_IN = 4'b0000;
        @(negedge CLK);

        // Single transfer with one-edge grant latency.
        set_src(0, 8'h5A, 32'hDEADBEEF);
        push(0, 8'h5A, 32'hDEADBEEF);
        REQ_IN = 4'b0001;
        @(negedge CLK);
        check("t1_latency_req", {63'd0, REQ_TO_BRIDGE}, 64'd1);
        check("t1_addr", {56'd0, ADDR_TO_BRIDGE}, 64'h5A);
        check("t1_data", {32'd0, DATA_TO_BRIDGE}, 64'hDEADBEEF);
        run_bridge(0, 1'b0);

        // Payload latched at grant ignores later DATA_IN changes.
        set_src(2, 8'h33, 32'h11111111);
        push(2, 8'h33, 32'h11111111);
        REQ_IN = 4'b0100;
        @(negedge CLK);
        DATA_IN[2*DW +: DW] = 32'h22222222;
        @(negedge CLK);
        check("t3_latched_data", {32'd0, DATA_TO_BRIDGE}, 64'h11111111);
        check("t3_still_req", {63'd0, REQ_TO_BRIDGE}, 64'd1);
        run_bridge(2, 1'b0);

        // Requester 1 keeps REQ high after its ACK: arbiter must stay in DRAIN.
        set_src(1, 8'h11, 32'h0BADF00D);
        push(1, 8'h11, 32'h0BADF00D);
        REQ_IN = 4'b0010;
        wait_req();
        ACK_FROM_BRIDGE = 1'b1;
        @(negedge CLK);
        check("t6_ack_rise", {60'd0, ACK_OUT}, 64'b0010);
        ACK_FROM_BRIDGE = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("t6_hold_busy", {63'd0, BUSY}, 64'd1);
            check("t6_hold_ack", {60'd0, ACK_OUT}, 64'b0010);
            check("t6_hold_noreq", {63'd0, REQ_TO_BRIDGE}, 64'd0);
        end
        REQ_IN[1] = 1'b0;
        @(negedge CLK);
        check("t6_done_busy", {63'd0, BUSY}, 64'd0);
        check("t6_done_ack", {60'd0, ACK_OUT}, 64'd0);

        // Asynchronous reset while requester 3 is in DRAIN.
        set_src(3, 8'hF3, 32'hFEEDFACE);
        push(3, 8'hF3, 32'hFEEDFACE);
        REQ_IN = 4'b1000;
        wait_req();
        ACK_FROM_BRIDGE = 1'b1;
        @(negedge CLK);
        check("t4_ack3", {60'd0, ACK_OUT}, 64'b1000);
        check("t4_grant3", {62'd0, GRANT_ID}, 64'd3);
        #2;
        RESET = 1'b1;
        #1;
        check("t4_async_reset", {16'd0, ACK_OUT, ADDR_TO_BRIDGE, DATA_TO_BRIDGE,
                                 REQ_TO_BRIDGE, GRANT_ID, BUSY}, 64'd0);
        ACK_FROM_BRIDGE = 1'b0;
        REQ_IN          = 4'b0000;
        @(negedge CLK);
        RESET = 1'b0;
        set_src(0, 8'h0A, 32'h00000A0A);
        push(0, 8'h0A, 32'h00000A0A);
        push(3, 8'hF3, 32'hFEEDFACE);
        REQ_IN = 4'b1001;
        run_bridge(0, 1'b0);
        run_bridge(3, 1'b0);

        repeat (3) @(negedge CLK);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
